// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Brief    : Forwarding, ALU, branch resolution and the EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrtEx,
  input  logic              ALUSrcEx,
  input  logic              MemWrtEx,
  input  logic              ResultSrcEx,
  input  logic              BranchEx,
  input  logic [2:0]        ALUControlEx,
  input  logic [DATA_W-1:0] RD1Ex,
  input  logic [DATA_W-1:0] RD2Ex,
  input  logic [DATA_W-1:0] Imm_ExtEx,
  input  logic [4:0]        RDEx,
  input  logic [DATA_W-1:0] PCEx,
  input  logic [DATA_W-1:0] PCplus4Ex,
  input  logic [1:0]        ForwardAEx,
  input  logic [1:0]        ForwardBEx,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcEx,
  output logic [DATA_W-1:0] PCTargetEx,
  output logic              RegWrtM,
  output logic              MemWrtM,
  output logic              ResultSrcM,
  output logic [4:0]        RDM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCplus4M
);

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_XOR = 3'b100;
  localparam logic [2:0] c_ALU_SLT = 3'b101;
  localparam logic [2:0] c_ALU_SLL = 3'b110;
  localparam logic [2:0] c_ALU_SRL = 3'b111;

  logic [DATA_W-1:0] w_src_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_src_b;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_zero;
  logic              w_lt;

  // Select 10 taps the registered result, so there is no path from the ALU back into itself.
  always_comb begin
    w_src_a = RD1Ex;
    case (ForwardAEx)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = ALUResultM;
      default: w_src_a = RD1Ex;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2Ex;
    case (ForwardBEx)
      2'b01:   w_fwd_b = ResultW;
      2'b10:   w_fwd_b = ALUResultM;
      default: w_fwd_b = RD2Ex;
    endcase
  end

  assign w_src_b = ALUSrcEx ? Imm_ExtEx : w_fwd_b;
  assign w_lt    = $signed(w_src_a) < $signed(w_src_b);

  always_comb begin
    w_alu_result = '0;
    case (ALUControlEx)
      c_ALU_ADD: w_alu_result = w_src_a + w_src_b;
      c_ALU_SUB: w_alu_result = w_src_a - w_src_b;
      c_ALU_AND: w_alu_result = w_src_a & w_src_b;
      c_ALU_OR:  w_alu_result = w_src_a | w_src_b;
      c_ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
      c_ALU_SLT: w_alu_result = {{(DATA_W-1){1'b0}}, w_lt};
      c_ALU_SLL: w_alu_result = w_src_a << w_src_b[4:0];
      c_ALU_SRL: w_alu_result = w_src_a >> w_src_b[4:0];
      default:   w_alu_result = '0;
    endcase
  end

  assign w_zero     = (w_alu_result == '0);
  assign PCSrcEx    = BranchEx & w_zero;
  assign PCTargetEx = PCEx + Imm_ExtEx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrtM    <= 1'b0;
      MemWrtM    <= 1'b0;
      ResultSrcM <= 1'b0;
      RDM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCplus4M   <= '0;
    end else begin
      RegWrtM    <= RegWrtEx;
      MemWrtM    <= MemWrtEx;
      ResultSrcM <= ResultSrcEx;
      RDM        <= RDEx;
      ALUResultM <= w_alu_result;
      WriteDataM <= w_fwd_b;
      PCplus4M   <= PCplus4Ex;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Brief    : Randomized and directed checks of execute_stage against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        RegWrtEx, ALUSrcEx, MemWrtEx, ResultSrcEx, BranchEx;
  logic [2:0]  ALUControlEx;
  logic [31:0] RD1Ex, RD2Ex, Imm_ExtEx, PCEx, PCplus4Ex, ResultW;
  logic [4:0]  RDEx;
  logic [1:0]  ForwardAEx, ForwardBEx;
  logic        PCSrcEx;
  logic [31:0] PCTargetEx;
  logic        RegWrtM, MemWrtM, ResultSrcM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM, PCplus4M;

  int checks;
  int failures;

  // Reference model of the EX/MEM register contents
  logic        m_regwrt, m_memwrt, m_ressrc;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  execute_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWrtEx(RegWrtEx), .ALUSrcEx(ALUSrcEx), .MemWrtEx(MemWrtEx),
    .ResultSrcEx(ResultSrcEx), .BranchEx(BranchEx), .ALUControlEx(ALUControlEx),
    .RD1Ex(RD1Ex), .RD2Ex(RD2Ex), .Imm_ExtEx(Imm_ExtEx), .RDEx(RDEx),
    .PCEx(PCEx), .PCplus4Ex(PCplus4Ex), .ForwardAEx(ForwardAEx),
    .ForwardBEx(ForwardBEx), .ResultW(ResultW),
    .PCSrcEx(PCSrcEx), .PCTargetEx(PCTargetEx), .RegWrtM(RegWrtM),
    .MemWrtM(MemWrtM), .ResultSrcM(ResultSrcM), .RDM(RDM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCplus4M(PCplus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return m_alu;
    return rf;
  endfunction

  task automatic model_reset();
    m_regwrt = 0; m_memwrt = 0; m_ressrc = 0; m_rd = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0;
  endtask

  task automatic clear_inputs();
    RegWrtEx = 0; ALUSrcEx = 0; MemWrtEx = 0; ResultSrcEx = 0; BranchEx = 0;
    ALUControlEx = 0; RD1Ex = 0; RD2Ex = 0; Imm_ExtEx = 0; RDEx = 0;
    PCEx = 0; PCplus4Ex = 0; ForwardAEx = 0; ForwardBEx = 0; ResultW = 0;
  endtask

  task automatic check_m_outputs(input string tag);
    check_val({tag, ".RegWrtM"},    {31'd0, RegWrtM},    {31'd0, m_regwrt});
    check_val({tag, ".MemWrtM"},    {31'd0, MemWrtM},    {31'd0, m_memwrt});
    check_val({tag, ".ResultSrcM"}, {31'd0, ResultSrcM}, {31'd0, m_ressrc});
    check_val({tag, ".RDM"},        {27'd0, RDM},        {27'd0, m_rd});
    check_val({tag, ".ALUResultM"}, ALUResultM, m_alu);
    check_val({tag, ".WriteDataM"}, WriteDataM, m_wd);
    check_val({tag, ".PCplus4M"},   PCplus4M,   m_pc4);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic do_cycle(input string tag);
    logic [31:0] a, fb, b, res;
    #1;
    a   = ref_fwd(ForwardAEx, RD1Ex);
    fb  = ref_fwd(ForwardBEx, RD2Ex);
    b   = ALUSrcEx ? Imm_ExtEx : fb;
    res = ref_alu(ALUControlEx, a, b);
    check_val({tag, ".PCSrcEx"}, {31'd0, PCSrcEx}, {31'd0, (BranchEx && res == 32'd0)});
    check_val({tag, ".PCTargetEx"}, PCTargetEx, PCEx + Imm_ExtEx);
    @(posedge clk);
    m_regwrt = RegWrtEx; m_memwrt = MemWrtEx; m_ressrc = ResultSrcEx;
    m_rd = RDEx; m_alu = res; m_wd = fb; m_pc4 = PCplus4Ex;
    #1;
    check_m_outputs(tag);
    @(negedge clk);
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    ALUControlEx = op; RD1Ex = a; RD2Ex = b;
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    checks = 0; failures = 0;
    sweep_exp[0] = 32'hFFFFFFF4; sweep_exp[1] = 32'hFFFFFFEC;
    sweep_exp[2] = 32'h00000000; sweep_exp[3] = 32'hFFFFFFF4;
    sweep_exp[4] = 32'hFFFFFFF4; sweep_exp[5] = 32'h00000001;
    sweep_exp[6] = 32'hFFFFFF00; sweep_exp[7] = 32'h0FFFFFFF;

    clear_inputs();
    model_reset();
    rst = 0;
    #3;
    check_m_outputs("reset_init");
    check_val("reset_init.PCSrcEx", {31'd0, PCSrcEx}, 32'd0);
    check_val("reset_init.PCTargetEx", PCTargetEx, 32'd0);
    @(negedge clk);
    rst = 1;

    // Load nonzero M state, then assert reset asynchronously mid-cycle
    clear_inputs();
    RegWrtEx = 1; MemWrtEx = 1; ResultSrcEx = 1; RDEx = 5'h11;
    ALUControlEx = 3'd0; RD1Ex = 32'h1234; RD2Ex = 32'h1; PCplus4Ex = 32'h44;
    do_cycle("preload");
    #2;
    rst = 0;
    model_reset();
    #1;
    check_m_outputs("async_reset");
    @(negedge clk);
    rst = 1;
    set_alu(3'd0, 32'd5, 32'd7);
    do_cycle("post_reset");
    check_val("post_reset.add", ALUResultM, 32'd12);

    // ALU sweep
    for (int op = 0; op < 8; op++) begin
      set_alu(op[2:0], 32'hFFFFFFF0, 32'h00000004);
      do_cycle("sweep");
      check_val($sformatf("sweep_op%0d", op), ALUResultM, sweep_exp[op]);
    end
    set_alu(3'd0, 32'hFFFFFFFF, 32'h1);
    do_cycle("add_wrap");
    check_val("add_wrap", ALUResultM, 32'd0);

    // Forwarding
    set_alu(3'd0, 32'd3, 32'd4);
    do_cycle("fwd_c1");
    check_val("fwd_c1", ALUResultM, 32'd7);
    set_alu(3'd1, 32'd99, 32'd1);
    ForwardAEx = 2'b10;
    do_cycle("fwd_c2");
    check_val("fwd_a_10", ALUResultM, 32'd6);
    set_alu(3'd0, 32'd10, 32'h77);
    ForwardBEx = 2'b01; ResultW = 32'h20; ALUSrcEx = 1; Imm_ExtEx = 32'h4;
    do_cycle("fwd_b_01");
    check_val("fwd_b_01.wd", WriteDataM, 32'h20);
    check_val("fwd_b_01.alu", ALUResultM, 32'd14);

    // Branch taken / not taken
    set_alu(3'd1, 32'h55, 32'h55);
    BranchEx = 1; PCEx = 32'h100; Imm_ExtEx = 32'hFFFFFFF8;
    #1;
    check_val("br_taken.PCSrcEx", {31'd0, PCSrcEx}, 32'd1);
    check_val("br_taken.PCTargetEx", PCTargetEx, 32'hF8);
    do_cycle("br_taken");
    set_alu(3'd1, 32'h55, 32'h56);
    BranchEx = 1; PCEx = 32'h100; Imm_ExtEx = 32'hFFFFFFF8;
    #1;
    check_val("br_not_taken.PCSrcEx", {31'd0, PCSrcEx}, 32'd0);
    do_cycle("br_not_taken");

    // Control passthrough, then a bubble
    clear_inputs();
    RegWrtEx = 1; ResultSrcEx = 1; RDEx = 5'h1F; PCplus4Ex = 32'h104;
    do_cycle("pass");
    check_val("pass.RDM", {27'd0, RDM}, 32'h1F);
    check_val("pass.PCplus4M", PCplus4M, 32'h104);
    clear_inputs();
    do_cycle("bubble");
    check_val("bubble.RegWrtM", {31'd0, RegWrtM}, 32'd0);

    // Reserved forward select
    set_alu(3'd0, 32'hA, 32'h1);
    ForwardAEx = 2'b11; ResultW = 32'hDEAD;
    do_cycle("fwd_11");
    check_val("fwd_11", ALUResultM, 32'hB);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      RegWrtEx = 1'($urandom); ALUSrcEx = 1'($urandom); MemWrtEx = 1'($urandom);
      ResultSrcEx = 1'($urandom); BranchEx = 1'($urandom);
      ALUControlEx = 3'($urandom);
      RD1Ex = $urandom; RD2Ex = ($urandom_range(0, 3) == 0) ? RD1Ex : $urandom;
      Imm_ExtEx = $urandom; RDEx = 5'($urandom); PCEx = $urandom;
      PCplus4Ex = $urandom; ResultW = $urandom;
      ForwardAEx = 2'($urandom_range(0, 3)); ForwardBEx = 2'($urandom_range(0, 3));
      do_cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Pipeline execute stage. It sits directly downstream of the decode stage and consumes that stage's registered Ex-side control and data outputs. It performs operand forwarding, ALU operation, branch resolution and branch-target generation. It registers results into the EX/MEM pipeline register, which feeds the memory stage and is also fed back internally for forwarding.

Parameters:
DATA_W, 32, datapath width. Only 32 is supported; shift amount is fixed at bits [4:0].

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
RegWrtEx  in  1  register-write enable from decode
ALUSrcEx  in  1  selects ALU operand B: 0 = forwarded RD2, 1 = Imm_ExtEx
MemWrtEx  in  1  memory-write enable
ResultSrcEx  in  1  writeback select: 0 = ALU, 1 = memory
BranchEx  in  1  instruction is a beq-type branch
ALUControlEx  in  3  ALU operation code
RD1Ex  in  32  register operand 1
RD2Ex  in  32  register operand 2
Imm_ExtEx  in  32  sign-extended immediate
RDEx  in  5  destination register
PCEx  in  32  instruction PC
PCplus4Ex  in  32  PC+4
ForwardAEx  in  2  operand A forward select, from hazard unit
ForwardBEx  in  2  operand B forward select, from hazard unit
ResultW  in  32  writeback-stage result
PCSrcEx  out  1  branch taken, combinational, to fetch
PCTargetEx  out  32  branch target, combinational, to fetch
RegWrtM  out  1  registered RegWrtEx
MemWrtM  out  1  registered MemWrtEx
ResultSrcM  out  1  registered ResultSrcEx
RDM  out  5  registered RDEx
ALUResultM  out  32  registered ALU result
WriteDataM  out  32  registered forwarded operand B (store data)
PCplus4M  out  32  registered PCplus4Ex

Behaviour:
- Forward mux A/B: 00 = RD1Ex/RD2Ex; 01 = ResultW; 10 = ALUResultM (this block's own register output); 11 = reserved, behaves as 00.
- SrcB = ALUSrcEx ? Imm_ExtEx : forwarded B. WriteData = forwarded B, never the immediate.
- ALU operations, 32-bit, wrap-around with no overflow flag:
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT, signed, result 1 or 0
  - 110 SLL by B[4:0]
  - 111 SRL (logical) by B[4:0]
- Zero = (ALU result == 0).
- PCSrcEx = BranchEx & Zero, combinational in the same cycle as the Ex inputs.
- PCTargetEx = PCEx + Imm_ExtEx, modulo 2^32, combinational.
- EX/MEM register: updates on every rising clk edge with all M outputs; latency 1 cycle. No stall or flush inputs; bubbles arrive from decode as zeroed control.
- Reset (rst=0, async, takes effect immediately including mid-operation): every registered M output = 0. PCSrcEx/PCTargetEx follow inputs combinationally, so they are 0 when the inputs are zero.
- On reset release, the first rising edge captures current Ex inputs normally.
- ForwardAEx=10 with ALUResultM just reset: forwards 0.
- Back-to-back dependency: the value forwarded via 10 is the result registered on the previous edge, never the current combinational ALU output (no combinational loop).

Test Plan:
- Reset: assert rst=0 mid-run with nonzero M outputs -> all M outputs 0 immediately without a clock edge. Release, apply ADD RD1=5, RD2=7, ALUSrc=0 -> next edge ALUResultM=12.
- ALU sweep: A=0xFFFFFFF0, B=0x00000004 -> ADD 0xFFFFFFF4, SUB 0xFFFFFFEC, AND 0, OR 0xFFFFFFF4, XOR 0xFFFFFFF4, SLT 1, SLL 0xFFFFFF00, SRL 0x0FFFFFFF. Also ADD 0xFFFFFFFF+1 -> 0.
- Forwarding: cycle 1 ADD 3+4 (ALUResultM=7 after edge). Cycle 2: ForwardAEx=10, RD1Ex=99, RD2Ex=1, SUB -> ALUResultM=6. ForwardBEx=01, ResultW=0x20, ALUSrcEx=1, Imm=0x4 -> WriteDataM=0x20, ALUResult uses 4.
- Branch: BranchEx=1, SUB with A=B=0x55, PCEx=0x100, Imm=0xFFFFFFF8 -> PCSrcEx=1, PCTargetEx=0xF8 in the same cycle. With A≠B -> PCSrcEx=0.
- Control passthrough: RegWrtEx=1, MemWrtEx=0, ResultSrcEx=1, RDEx=0x1F, PCplus4Ex=0x104 -> next edge M outputs match. A bubble (all zero) on the following cycle -> M control outputs 0.
- Reserved select: ForwardAEx=11, RD1Ex=0xA, RD2Ex=0x1, ADD -> ALUResultM=0xB.
